dotprod_accum: RTL and testbench
================================

Name: dotprod_accum

Overview:
- Downstream consumer of the pipelined dot-product unit.
- Accumulates NUM_TILES consecutive partial dot products (K-dimension tiling) into one output element.
- Adds a per-element bias, saturates to DATA_W, and optionally applies ReLU.
- Buffers results in a small first-word-fall-through FIFO with a valid/ready output handshake, because the dot-product pipeline cannot stall.

Parameters:
- DATA_W, 32, width of partial sums, bias and output data.
- NUM_TILES, 4, partial sums per output element (>=1).
- FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2).
- RELU, 1, 1 = clamp negative results to 0; 0 = pass through.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  in_psum carries a partial sum this cycle (upstream aligns it to the dot-product latency).
- in_psum  input  DATA_W  signed partial dot product.
- in_bias  input  DATA_W  signed bias; sampled only on the first beat of a group.
- in_ready  output  1  block can accept a beat this cycle.
- out_valid  output  1  out_data/out_sat hold a valid result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_W  signed saturated (and ReLU'd) result.
- out_sat  output  1  saturation occurred for this result.
- drop_err  output  1  sticky: a beat arrived while in_ready=0.

Behaviour:
- Beat accepted iff in_valid && in_ready.
- in_ready = !fifo_full. It is a registered-state function with no combinational path from out_ready.
- Accumulator width ACC_W = DATA_W + $clog2(NUM_TILES) + 1; all operands are sign-extended to ACC_W.
- tile_cnt counts 0..NUM_TILES-1 and advances only on accepted beats, wrapping to 0 after the last beat.
- Accepted beat, tile_cnt==0: acc <= sext(in_bias) + sext(in_psum).
- Accepted beat, other tile_cnt: acc <= acc + sext(in_psum).
- Last beat (tile_cnt==NUM_TILES-1):
  - final = (tile_cnt==0 ? sext(in_bias) : acc) + sext(in_psum).
  - Saturate final to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat=1 if clamped.
  - If RELU and the saturated value <0, the result is 0. sat is unaffected by ReLU.
  - {result, sat} is pushed into the FIFO at the same edge.
- NUM_TILES==1: every beat is a last beat (bias+psum).
- Latency: last beat accepted at edge N gives out_valid=1 after edge N, when the FIFO was empty.
- Zero idle cycles are required between groups. Back-to-back groups are accepted at 1 beat/cycle while in_ready=1.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr wrapping modulo FIFO_DEPTH and count 0..FIFO_DEPTH.
  - out_valid = (count!=0).
  - out_data/out_sat = head entry; both are driven 0 when empty.
- Pop iff out_valid && out_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Empty FIFO with a push: no pop is possible that cycle, since out_valid=0.
- Full FIFO: in_ready=0, so no push. A pop that cycle raises in_ready on the next cycle.
- in_ready=0 blocks all beats, including non-last beats of a partially accumulated group. The group resumes intact when in_ready returns.
- in_valid && !in_ready:
  - The beat is dropped; acc and tile_cnt are unchanged.
  - drop_err <= 1, which clears only on reset.
- Output stability: while out_valid && !out_ready, out_data/out_sat are held.
- Reset (rst_n==0 at a clk edge) forces all of the following:
  - acc=0, tile_cnt=0, pointers=0, count=0.
  - out_valid=0, out_data=0, out_sat=0, drop_err=0.
  - in_ready=1 in the cycle after reset.
  - Any partial group or buffered results are discarded.
- There is no asynchronous behaviour.

Test Plan:
Configuration is DATA_W=32, NUM_TILES=4, FIFO_DEPTH=4, RELU=1 unless noted.
1. Basic: bias=10, psums 1,2,3,4 on consecutive cycles, out_ready=1 -> a single out_valid pulse one cycle after the 4th beat, out_data=20, out_sat=0.
2. ReLU: bias=0, psums -5,-5,-5,-5 -> out_data=0, out_sat=0. Same stimulus with RELU=0 -> out_data=-20.
3. Saturation:
   - bias=0x7FFFFFFF, psums 1,0,0,0 -> out_data=0x7FFFFFFF, out_sat=1.
   - RELU=0, bias=0x80000000, psums -1,0,0,0 -> out_data=0x80000000, out_sat=1.
4. Backpressure/wrap: out_ready=0, send 4 groups with biases 1..4 and psums 0 -> in_ready=0 after the 4th push. Bench holds the 5th group (bias=5). Then out_ready=1 -> outputs 1,2,3,4,5 in order with drop_err=0; a further 6 groups exercise pointer wrap-around.
5. Drop: FIFO full, drive in_valid with psum=7 -> drop_err=1, tile_cnt unchanged. The next accepted group sums correctly, and drop_err stays 1 until rst_n=0.
6. Reset mid-group: 2 beats of a group, rst_n=0 for one edge, then bias=1 with psums 1,1,1,1 -> out_data=5, no stale output, out_valid=0 throughout reset.

Source files
------------

// File: rtl/dotprod_accum_if.sv
// Stream interface of the dot-product accumulator: partial-sum input beats
// and the buffered result output, each with a valid/ready handshake.
interface dotprod_accum_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_psum;
  logic [DATA_W-1:0] in_bias;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;

  modport slave (
    input  in_valid, in_psum, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_psum, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/dotprod_accum.sv
// Accumulates NUM_TILES partial dot products per output element, adds a bias,
// saturates to DATA_W, optionally applies ReLU and buffers results in a FWFT FIFO.
module dotprod_accum #(
  parameter int DATA_W     = 32,
  parameter int NUM_TILES  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int RELU       = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  dotprod_accum_if.slave bus,
  output logic           drop_err
);

  localparam int CNT_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int ACC_W = DATA_W + $clog2(NUM_TILES) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0]        LAST_TILE = CNT_W'(NUM_TILES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;
  localparam logic [PTR_W:0]          FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] psum_x;
  logic signed [ACC_W-1:0] bias_x;
  logic signed [ACC_W-1:0] sum_base;
  logic signed [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0]        tile_cnt;

  logic [DATA_W-1:0]     mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_sat;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  logic              full;
  logic              accept;
  logic              last_beat;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] res_data;
  logic              res_sat;

  assign psum_x    = ACC_W'($signed(bus.in_psum));
  assign bias_x    = ACC_W'($signed(bus.in_bias));
  assign full      = (count == FULL_CNT);
  assign accept    = bus.in_valid && bus.in_ready;
  assign last_beat = (tile_cnt == LAST_TILE);
  assign push      = accept && last_beat;
  assign pop       = bus.out_valid && bus.out_ready;

  // in_ready depends only on registered count, never on out_ready
  assign bus.in_ready  = !full;
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = (count != '0) ? mem_data[rd_ptr] : '0;
  assign bus.out_sat   = (count != '0) ? mem_sat[rd_ptr]  : 1'b0;

  always_comb begin
    sum_base = (tile_cnt == '0) ? bias_x : acc;
    sum_next = sum_base + psum_x;
    res_data = sum_next[DATA_W-1:0];
    res_sat  = 1'b0;
    if (sum_next > SAT_MAX) begin
      res_data = SAT_MAX[DATA_W-1:0];
      res_sat  = 1'b1;
    end else if (sum_next < SAT_MIN) begin
      res_data = SAT_MIN[DATA_W-1:0];
      res_sat  = 1'b1;
    end
    // ReLU applies after saturation and leaves the sat flag alone
    if ((RELU != 0) && res_data[DATA_W-1]) begin
      res_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      tile_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (accept) begin
        acc      <= sum_next;
        tile_cnt <= last_beat ? '0 : tile_cnt + CNT_W'(1);
      end
      if (bus.in_valid && !bus.in_ready) begin
        drop_err <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= res_data;
      mem_sat[wr_ptr]  <= res_sat;
    end
  end

endmodule

// File: tb/tb_dotprod_accum.sv
// Self-checking bench: two accumulators (RELU=1 and RELU=0) share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_dotprod_accum;

  localparam int DW    = 32;
  localparam int NT    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
  } res_t;

  logic clk;
  logic rst_n;
  logic drop1, drop0;

  dotprod_accum_if #(.DATA_W(DW)) bus1 ();
  dotprod_accum_if #(.DATA_W(DW)) bus0 ();

  dotprod_accum #(.DATA_W(DW), .NUM_TILES(NT), .FIFO_DEPTH(DEPTH), .RELU(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus1),
    .drop_err (drop1)
  );

  dotprod_accum #(.DATA_W(DW), .NUM_TILES(NT), .FIFO_DEPTH(DEPTH), .RELU(0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus0),
    .drop_err (drop0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  res_t   q1[$];
  res_t   q0[$];
  longint grp_sum;
  int     grp_n;
  logic   m_drop;
  logic [31:0] popped[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int psum, input int bias);
    bus1.in_valid = v;  bus0.in_valid = v;
    bus1.in_psum  = psum; bus0.in_psum = psum;
    bus1.in_bias  = bias; bus0.in_bias = bias;
  endtask

  task automatic set_ordy(input logic r);
    bus1.out_ready = r;
    bus0.out_ready = r;
  endtask

  // Advance the model by one clock edge using the inputs presented now
  task automatic model_edge();
    logic   ok, pp;
    longint f;
    res_t   r;
    if (!rst_n) begin
      q1.delete(); q0.delete();
      grp_sum = 0; grp_n = 0; m_drop = 1'b0;
      return;
    end
    ok = bus1.in_valid && (q1.size() < DEPTH);
    pp = (q1.size() != 0) && bus1.out_ready;
    if (bus1.in_valid && !ok) m_drop = 1'b1;
    if (pp) begin
      popped.push_back(q1[0].d);
      void'(q1.pop_front());
      void'(q0.pop_front());
    end
    if (ok) begin
      if (grp_n == 0) grp_sum = longint'($signed(bus1.in_bias)) + longint'($signed(bus1.in_psum));
      else            grp_sum = grp_sum + longint'($signed(bus1.in_psum));
      grp_n++;
      if (grp_n == NT) begin
        f = grp_sum;
        if (f > 64'sd2147483647) begin
          r.d = 32'h7FFF_FFFF; r.s = 1'b1;
        end else if (f < -64'sd2147483648) begin
          r.d = 32'h8000_0000; r.s = 1'b1;
        end else begin
          r.d = f[31:0]; r.s = 1'b0;
        end
        q0.push_back(r);
        if (r.d[31]) r.d = '0;
        q1.push_back(r);
        grp_n = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready1",  bus1.in_ready,  q1.size() < DEPTH);
    chk("in_ready0",  bus0.in_ready,  q0.size() < DEPTH);
    chk("out_valid1", bus1.out_valid, q1.size() != 0);
    chk("out_valid0", bus0.out_valid, q0.size() != 0);
    chk("out_data1",  bus1.out_data,  (q1.size() != 0) ? q1[0].d : 32'd0);
    chk("out_data0",  bus0.out_data,  (q0.size() != 0) ? q0[0].d : 32'd0);
    chk("out_sat1",   bus1.out_sat,   (q1.size() != 0) ? q1[0].s : 1'b0);
    chk("out_sat0",   bus0.out_sat,   (q0.size() != 0) ? q0[0].s : 1'b0);
    chk("drop_err1",  drop1, m_drop);
    chk("drop_err0",  drop0, m_drop);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic send_group(input int bias, input int p0, input int p1, input int p2, input int p3);
    int ps[4];
    ps[0] = p0; ps[1] = p1; ps[2] = p2; ps[3] = p3;
    for (int k = 0; k < NT; k++) begin
      for (int w = 0; w < 40 && !bus1.in_ready; w++) begin
        drive(1'b0, 0, 0);
        step();
      end
      if (!bus1.in_ready) chk("ready_wait", bus1.in_ready, 1'b1);
      drive(1'b1, ps[k], bias);
      step();
    end
    drive(1'b0, 0, 0);
  endtask

  task automatic drain();
    set_ordy(1'b1);
    drive(1'b0, 0, 0);
    for (int w = 0; w < 20 && (bus1.out_valid || bus0.out_valid); w++) step();
    chk("drain", bus1.out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 0, 0);
    set_ordy(1'b0);
    step();
    step();
    chk("rst_ready", bus1.in_ready, 1'b1);
    chk("rst_valid", bus1.out_valid, 1'b0);
    chk("rst_data",  bus1.out_data, 32'd0);
    chk("rst_drop",  drop1, 1'b0);
    rst_n = 1'b1;

    // basic group
    set_ordy(1'b1);
    send_group(10, 1, 2, 3, 4);
    chk("basic_valid", bus1.out_valid, 1'b1);
    chk("basic_data",  bus1.out_data, 32'd20);
    chk("basic_sat",   bus1.out_sat, 1'b0);
    step();
    chk("basic_pulse", bus1.out_valid, 1'b0);

    // ReLU on / off
    send_group(0, -5, -5, -5, -5);
    chk("relu_data1", bus1.out_data, 32'd0);
    chk("relu_sat1",  bus1.out_sat, 1'b0);
    chk("relu_data0", bus0.out_data, 32'hFFFF_FFEC);
    drain();

    // positive and negative saturation
    send_group(32'h7FFF_FFFF, 1, 0, 0, 0);
    chk("satp_data", bus1.out_data, 32'h7FFF_FFFF);
    chk("satp_sat",  bus1.out_sat, 1'b1);
    drain();
    send_group(32'h8000_0000, -1, 0, 0, 0);
    chk("satn_data0", bus0.out_data, 32'h8000_0000);
    chk("satn_sat0",  bus0.out_sat, 1'b1);
    chk("satn_data1", bus1.out_data, 32'd0);
    chk("satn_sat1",  bus1.out_sat, 1'b1);
    drain();

    // backpressure, fill, hold, release and wrap
    set_ordy(1'b0);
    for (int g = 1; g <= 4; g++) send_group(g, 0, 0, 0, 0);
    chk("full_ready", bus1.in_ready, 1'b0);
    popped.delete();
    set_ordy(1'b1);
    send_group(5, 0, 0, 0, 0);
    drain();
    chk("bp_count", popped.size(), 5);
    for (int i = 0; i < 5 && i < popped.size(); i++) chk("bp_order", popped[i], i + 1);
    chk("bp_drop", drop1, 1'b0);
    for (int g = 0; g < 6; g++)
      send_group($urandom_range(1000), $urandom_range(50), $urandom_range(50),
                 $urandom_range(50), $urandom_range(50));
    drain();

    // reset mid-group
    drive(1'b1, 1, 50);
    step();
    drive(1'b1, 2, 50);
    step();
    rst_n = 1'b0;
    drive(1'b0, 0, 0);
    step();
    chk("rst_mid_valid1", bus1.out_valid, 1'b0);
    chk("rst_mid_valid0", bus0.out_valid, 1'b0);
    rst_n = 1'b1;
    send_group(1, 1, 1, 1, 1);
    chk("rst_mid_data", bus1.out_data, 32'd5);
    drain();

    // drop while full
    set_ordy(1'b0);
    for (int g = 0; g < 4; g++) send_group(0, 0, 0, 0, 0);
    drive(1'b1, 7, 0);
    step();
    chk("drop_set", drop1, 1'b1);
    popped.delete();
    set_ordy(1'b1);
    send_group(100, 1, 2, 3, 4);
    drain();
    chk("drop_count", popped.size(), 5);
    if (popped.size() > 0) chk("drop_sum", popped[popped.size()-1], 32'd110);
    chk("drop_sticky", drop1, 1'b1);

    // randomized traffic with drops, backpressure and extreme values
    for (int c = 0; c < 600; c++) begin
      int p, b;
      case ($urandom_range(3))
        0:       p = int'($urandom);
        1:       p = ($urandom_range(1)) ? 32'h7FFF_FFFF : 32'h8000_0000;
        default: p = int'($urandom_range(200)) - 100;
      endcase
      b = ($urandom_range(3) == 0) ? int'($urandom) : int'($urandom_range(200)) - 100;
      drive($urandom_range(9) < 7, p, b);
      set_ordy($urandom_range(9) < 6);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
